rr_merge_join: RTL and testbench

//   Two-input valid/ready stream merge with weighted round-robin arbitration and a registered output.

---
 rtl/rr_merge_join.sv | 100 ++++++++++
 tb/tb_rr_merge_join.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_merge_join.sv
// Two-input valid/ready merge with weighted round-robin arbitration.
// The output register tags each word with its source (0=A, 1=B).
module rr_merge_join #(
    parameter int unsigned D_WIDTH   = 6,
    parameter int unsigned BURST_LEN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data_a,
    input  logic               up_valid_a,
    output logic               up_ready_a,
    input  logic [D_WIDTH-1:0] up_data_b,
    input  logic               up_valid_b,
    output logic               up_ready_b,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_src,
    output logic               down_valid,
    input  logic               down_ready
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    logic               ld;
    logic               grant_a, grant_b, holder_grant;
    logic               prio_q, prio_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic               src_q, src_d;
    logic               valid_q, valid_d;

    // Grants are only issued when the output register can load, so a
    // contested pair under backpressure leaves the priority state untouched.
    always_comb begin
        ld      = !valid_q || down_ready;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && ld) begin
            if (up_valid_a && (!up_valid_b || !prio_q)) begin
                grant_a = 1'b1;
            end else if (up_valid_b) begin
                grant_b = 1'b1;
            end
        end
    end

    assign up_ready_a = grant_a;
    assign up_ready_b = grant_b;

    always_comb begin
        data_d       = data_q;
        src_d        = src_q;
        valid_d      = valid_q;
        prio_d       = prio_q;
        cnt_d        = cnt_q;
        holder_grant = (grant_a && !prio_q) || (grant_b && prio_q);

        if (grant_a) begin
            data_d  = up_data_a;
            src_d   = 1'b0;
            valid_d = 1'b1;
        end else if (grant_b) begin
            data_d  = up_data_b;
            src_d   = 1'b1;
            valid_d = 1'b1;
        end else if (down_ready) begin
            valid_d = 1'b0;
        end

        if (holder_grant) begin
            if (cnt_q == CNT_LAST) begin
                prio_d = ~prio_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            src_q   <= 1'b0;
            valid_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    assign down_data  = data_q;
    assign down_src   = src_q;
    assign down_valid = valid_q;

endmodule

// File: tb/tb_rr_merge_join.sv
// Randomized and directed checks of rr_merge_join against a queue-based
// reference model of the merge, its output register and its arbitration.
module tb_rr_merge_join;

    localparam int unsigned DW = 6;
    localparam int unsigned BL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] up_data_a, up_data_b, down_data;
    logic          up_valid_a, up_ready_a, up_valid_b, up_ready_b;
    logic          down_src, down_valid, down_ready;

    always #5 clk = ~clk;

    rr_merge_join #(
        .D_WIDTH  (DW),
        .BURST_LEN(BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_data_a (up_data_a),
        .up_valid_a(up_valid_a),
        .up_ready_a(up_ready_a),
        .up_data_b (up_data_b),
        .up_valid_b(up_valid_b),
        .up_ready_b(up_ready_b),
        .down_data (down_data),
        .down_src  (down_src),
        .down_valid(down_valid),
        .down_ready(down_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: the output register and who currently holds priority.
    bit m_valid  = 0;
    int m_data   = 0;
    bit m_src    = 0;
    int holder   = 0;
    int streak   = 0;

    int qa[$], qb[$];
    int acc_data[$];
    int acc_src[$];
    int p_a, p_b, p_dr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // A valid that has not been taken stays up with the same word.
    task automatic drive_inputs(input bit took_a, input bit took_b);
        if (!up_valid_a || took_a)
            up_valid_a = (qa.size() > 0) && ($urandom_range(99) < p_a);
        if (!up_valid_b || took_b)
            up_valid_b = (qb.size() > 0) && ($urandom_range(99) < p_b);
        up_data_a  = up_valid_a ? DW'(qa[0]) : DW'($urandom);
        up_data_b  = up_valid_b ? DW'(qb[0]) : DW'($urandom);
        down_ready = ($urandom_range(99) < p_dr);
    endtask

    task automatic cycle(input bit r);
        bit ld, ga, gb, from_holder;
        rst = r;
        @(negedge clk);
        ld = !m_valid || down_ready;
        ga = 0;
        gb = 0;
        if (!r && ld) begin
            if (up_valid_a && up_valid_b) begin
                if (holder == 0) ga = 1;
                else gb = 1;
            end else if (up_valid_a) ga = 1;
            else if (up_valid_b) gb = 1;
        end
        check("ready_a", up_ready_a, ga);
        check("ready_b", up_ready_b, gb);
        check("down_valid", down_valid, m_valid);
        check("down_data", down_data, m_data);
        check("down_src", down_src, m_src);
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = 0; m_src = 0; holder = 0; streak = 0;
        end else begin
            if (m_valid && down_ready) begin
                acc_data.push_back(m_data);
                acc_src.push_back(int'(m_src));
            end
            if (ga || gb) begin
                m_data  = ga ? int'(up_data_a) : int'(up_data_b);
                m_src   = gb;
                m_valid = 1;
                from_holder = (ga && holder == 0) || (gb && holder == 1);
                if (from_holder) begin
                    streak++;
                    if (streak == BL) begin
                        holder = 1 - holder;
                        streak = 0;
                    end
                end
            end else if (m_valid && down_ready) begin
                m_valid = 0;
            end
        end
        #1;
        if (ga) void'(qa.pop_front());
        if (gb) void'(qb.pop_front());
        drive_inputs(ga, gb);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0);
    endtask

    task automatic do_reset();
        cycle(1);
        acc_data.delete();
        acc_src.delete();
    endtask

    task automatic check_log(input string tag, input int exp_d[$], input int exp_s[$]);
        check({tag, "_count"}, acc_data.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < acc_data.size(); i++) begin
            check({tag, "_data"}, acc_data[i], exp_d[i]);
            check({tag, "_src"}, acc_src[i], exp_s[i]);
        end
    endtask

    initial begin
        rst = 1; up_valid_a = 0; up_valid_b = 0; up_data_a = 0; up_data_b = 0;
        down_ready = 0;
        p_a = 0; p_b = 0; p_dr = 0;
        do_reset();
        do_reset();

        // A-only stream back to back
        qa = '{'h01, 'h02, 'h03};
        p_a = 100; p_b = 0; p_dr = 100;
        drive_inputs(1, 1);
        run(5);
        check_log("a_only", '{'h01, 'h02, 'h03}, '{0, 0, 0});

        // Both always valid: bursts of two per source
        do_reset();
        qa = '{'h0A, 'h0B, 'h0C, 'h0D};
        qb = '{'h1A, 'h1B, 'h1C, 'h1D};
        p_a = 100; p_b = 100; p_dr = 100;
        drive_inputs(1, 1);
        run(10);
        check_log("burst", '{'h0A, 'h0B, 'h1A, 'h1B, 'h0C, 'h0D, 'h1C, 'h1D},
                  '{0, 0, 1, 1, 0, 0, 1, 1});

        // Backpressure holds 0x15 for three cycles
        do_reset();
        qa = '{'h15, 'h16, 'h17};
        p_a = 100; p_b = 0; p_dr = 100;
        drive_inputs(1, 1);
        p_dr = 0;
        cycle(0);
        for (int i = 0; i < 3; i++) begin
            cycle(0);
            check("hold_data", down_data, 'h15);
            check("hold_rdy", {up_ready_a, up_ready_b}, 2'b00);
        end
        p_dr = 100;
        down_ready = 1;
        run(5);
        check_log("hold", '{'h15, 'h16, 'h17}, '{0, 0, 0});

        // B-only words do not consume A's priority
        do_reset();
        qb = '{'h21, 'h22};
        p_a = 0; p_b = 100; p_dr = 100;
        drive_inputs(1, 1);
        run(3);
        qa = '{'h05, 'h06};
        qb.push_back('h23);
        p_a = 100;
        drive_inputs(1, 1);
        run(6);
        check_log("nonholder", '{'h21, 'h22, 'h05, 'h06, 'h23}, '{1, 1, 0, 0, 1});

        // Reset while a word sits in the output register
        do_reset();
        qa = '{'h30, 'h31};
        p_a = 100; p_b = 0; p_dr = 100;
        drive_inputs(1, 1);
        p_dr = 0;
        cycle(0);
        check("pre_rst_valid", down_valid, 1'b1);
        rst = 1;
        #1;
        check("rst_ready_a", up_ready_a, 1'b0);
        cycle(1);
        check("post_rst_valid", down_valid, 1'b0);
        acc_data.delete();
        acc_src.delete();
        p_dr = 100;
        down_ready = 1;
        run(4);
        check_log("after_rst", '{'h31}, '{0});

        // Random traffic, backpressure and occasional reset
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                p_a  = $urandom_range(100);
                p_b  = $urandom_range(100);
                p_dr = $urandom_range(100);
            end
            while (qa.size() < 4) qa.push_back($urandom_range(63));
            while (qb.size() < 4) qb.push_back($urandom_range(63));
            cycle($urandom_range(199) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
